pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning payload width in bits (WIDTH >= 1).
REQ-002 SHALL have parameter CTRL_WIDTH, default 16, meaning payload LSBs treated as control bits and forced to 0 in a bubble (1 <= CTRL_WIDTH <= WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  drops all held entries (branch mispredict or squash).
REQ-006 SHALL have port in_valid  input  1  the upstream stage offers in_data.
REQ-007 SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload (control bits in [CTRL_WIDTH-1:0]).
REQ-009 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-010 SHALL have port out_ready  input  1  the downstream stage consumes out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  the oldest held payload.
REQ-012 SHALL have port count  output  2  occupancy: 0, 1 or 2.

Function
REQ-013 SHALL hold two WIDTH-bit registers: main (head) and skid (overflow); state EMPTY (count 0), HALF (1), FULL (2).
REQ-014 A transfer in SHALL occur when in_valid & in_ready; a transfer out SHALL occur when out_valid & out_ready.
REQ-015 in_ready SHALL equal (state != FULL), decoded from the state register only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL equal (state != EMPTY).
REQ-017 out_data[WIDTH-1:CTRL_WIDTH] SHALL equal main; out_data[CTRL_WIDTH-1:0] SHALL equal main's low bits when out_valid, else 0 (bubble = NOP).
REQ-018 EMPTY: transfer in -> HALF, main <= in_data; otherwise stay EMPTY.
REQ-019 HALF: in and out together -> HALF, main <= in_data; in only -> FULL, skid <= in_data; out only -> EMPTY; neither -> hold.
REQ-020 FULL: out -> HALF, main <= skid; no out -> hold; no transfer in is possible.
REQ-021 Latency SHALL be 1 cycle, in_data accepted at edge N appears on out_data after edge N; sustained throughput SHALL be 1 transfer per cycle with out_ready held high.
REQ-022 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or lost except by flush or reset.
REQ-023 flush SHALL take priority over transfers: next state EMPTY, and any in_data or out_ready in the flush cycle is ignored (no write).
REQ-024 In the flush cycle, in_ready and out_valid SHALL still reflect the pre-flush state; the upstream sender SHALL treat the dropped beat as squashed.
REQ-025 count SHALL be a registered encoding of the state: EMPTY=0, HALF=1, FULL=2; the value 3 SHALL never appear.
REQ-026 main and skid SHALL hold their value in every cycle they are not written.

Reset
REQ-027 While reset is high at a clock edge, the state SHALL become EMPTY and main and skid SHALL become all-zero; reset SHALL take priority over flush and over transfers.
REQ-028 After reset: in_ready=1, out_valid=0, out_data=0, count=0.
REQ-029 Reset asserted mid-operation, including in FULL, SHALL discard both entries within one edge with no partial update.

Verification (WIDTH=8, CTRL_WIDTH=4)
REQ-030 Reset -> in_ready=1, out_valid=0, out_data=8'h00, count=0.
REQ-031 Streaming with out_ready=1 and in_valid=1, data 8'hA1, 8'hB2, 8'hC3 on consecutive cycles -> out_data is A1, B2, C3 one cycle later each; count stays 1.
REQ-032 Backpressure: out_ready=0, send 8'h11 then 8'h22 -> count=2, in_ready=0, out_data=8'h11; a third beat 8'h33 is held off; raise out_ready -> outputs 11, 22, 33 in order with no loss.
REQ-033 Flush while FULL, with in_valid=1 and in_data=8'h5F -> next cycle count=0, out_valid=0, out_data[3:0]=0; 8'h5F is never output.
REQ-034 Bubble: main=8'hE7, consumed with no new input -> out_valid=0, out_data=8'hE0.
REQ-035 reset and flush together while HALF -> all-zero state; a random 10k-cycle valid/ready/flush stress test against a queue model gives no ordering, count or in_ready mismatch.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register. in_ready is decoded from registered state only,
// which breaks the ready path between stages while sustaining one beat per cycle.
module pipe_skid_reg #(
    parameter int WIDTH      = 64,
    parameter int CTRL_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Handshake: a beat moves on a rising edge when valid & ready are both high on
    // that side. valid never waits on ready. in_ready and out_valid come from state_q
    // alone, and so they still show the pre-flush state during a flush cycle.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b1}} >> (WIDTH - CTRL_WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             xfer_in;
    logic             xfer_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_HALF;
                        main_d  = in_data;
                    end
                end
                ST_HALF: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_data;
                    end else if (xfer_in) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain into main can happen.
                    if (xfer_out) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        out_data  = out_valid ? main_q : (main_q & ~CTRL_MASK);
        count     = state_q;
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg at WIDTH=8, CTRL_WIDTH=4: directed vector table plus a
// randomized valid/ready/flush/reset run against a queue model.
module tb_pipe_skid_reg;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int total;
    int bad;

    pipe_skid_reg #(.WIDTH(8), .CTRL_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic rst, input logic fl, input logic iv, input logic [7:0] d,
                           input logic ordy, input logic e_ir, input logic e_ov,
                           input logic [7:0] e_od, input logic [1:0] e_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    initial begin
        logic r_rst, r_fl, r_iv, r_or;
        logic [7:0] r_d;
        logic m_ir, m_ov;
        total = 0;
        bad   = 0;

        //      rst fl iv data   ordy  ir ov out    cnt
        add_vec(1, 0, 0, 8'h00, 0,    1, 0, 8'h00, 0);   // reset state
        add_vec(0, 0, 1, 8'hA1, 1,    1, 1, 8'hA1, 1);   // streaming
        add_vec(0, 0, 1, 8'hB2, 1,    1, 1, 8'hB2, 1);
        add_vec(0, 0, 1, 8'hC3, 1,    1, 1, 8'hC3, 1);
        add_vec(0, 0, 0, 8'h00, 1,    1, 0, 8'hC0, 0);
        add_vec(0, 0, 1, 8'h11, 0,    1, 1, 8'h11, 1);   // backpressure
        add_vec(0, 0, 1, 8'h22, 0,    0, 1, 8'h11, 2);
        add_vec(0, 0, 1, 8'h33, 0,    0, 1, 8'h11, 2);   // third beat held off
        add_vec(0, 0, 1, 8'h33, 1,    1, 1, 8'h22, 1);
        add_vec(0, 0, 1, 8'h33, 1,    1, 1, 8'h33, 1);
        add_vec(0, 0, 0, 8'h00, 1,    1, 0, 8'h30, 0);
        add_vec(0, 0, 1, 8'h44, 0,    1, 1, 8'h44, 1);   // flush while full
        add_vec(0, 0, 1, 8'h55, 0,    0, 1, 8'h44, 2);
        add_vec(0, 1, 1, 8'h5F, 1,    1, 0, 8'h40, 0);
        add_vec(0, 0, 0, 8'h00, 1,    1, 0, 8'h40, 0);
        add_vec(0, 0, 1, 8'hE7, 0,    1, 1, 8'hE7, 1);   // bubble
        add_vec(0, 0, 0, 8'h00, 1,    1, 0, 8'hE0, 0);
        add_vec(0, 0, 1, 8'h9A, 0,    1, 1, 8'h9A, 1);   // reset + flush in half
        add_vec(1, 1, 1, 8'hBC, 1,    1, 0, 8'h00, 0);
        add_vec(0, 0, 1, 8'h12, 0,    1, 1, 8'h12, 1);   // reset in full
        add_vec(0, 0, 1, 8'h34, 0,    0, 1, 8'h12, 2);
        add_vec(1, 0, 1, 8'h56, 1,    1, 0, 8'h00, 0);
        add_vec(0, 0, 1, 8'h78, 0,    1, 1, 8'h78, 1);
        add_vec(0, 0, 0, 8'h00, 1,    1, 0, 8'h70, 0);
        add_vec(0, 0, 1, 8'hAB, 0,    1, 1, 8'hAB, 1);   // flush in half with in+out
        add_vec(0, 1, 1, 8'hCD, 1,    1, 0, 8'hA0, 0);
        add_vec(0, 0, 0, 8'hEE, 0,    1, 0, 8'hA0, 0);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].e_od));
            check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
        end

        // Randomized run: model is a queue of at most two beats.
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            m_ir = (exp_q.size() < 2);
            m_ov = (exp_q.size() != 0);
            check("rnd in_ready",  32'(in_ready),  32'(m_ir));
            check("rnd out_valid", 32'(out_valid), 32'(m_ov));
            check("rnd count",     32'(count),     32'(exp_q.size()));
            if (m_ov) check("rnd out_data", 32'(out_data), 32'(exp_q[0]));
            else      check("rnd bubble ctrl", 32'(out_data[3:0]), 32'(0));

            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            r_d   = 8'($urandom_range(0, 255));
            reset = r_rst; flush = r_fl; in_valid = r_iv; out_ready = r_or; in_data = r_d;
            @(posedge clk);
            if (r_rst || r_fl) begin
                exp_q.delete();
            end else begin
                if (m_ov && r_or) void'(exp_q.pop_front());
                if (m_ir && r_iv) exp_q.push_back(r_d);
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
